mips_div_unit: RTL



---
 rtl/mips_div_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mips_div_unit.sv
// Iterative 32-bit restoring divider for DIV/DIVU, one quotient bit per clock.
// Define DIV_SIGNED_EN to enable signed division (sign_op=1); otherwise every operation is unsigned.
module mips_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_q, state_nx;
    logic [WIDTH-1:0] rem_q, rem_nx;
    logic [WIDTH-1:0] dvd_q, dvd_nx;
    logic [WIDTH-1:0] dsr_q, dsr_nx;
    logic [WIDTH-1:0] a_raw_q, a_raw_nx;
    logic [CW-1:0]    cnt_q, cnt_nx;
    logic             sign_a_q, sign_a_nx;
    logic             sign_b_q, sign_b_nx;
    logic [WIDTH-1:0] quotient_nx, remainder_nx;
    logic             busy_nx, done_nx, dbz_nx;

    // Shifted partial remainder keeps the bit shifted out of rem, so large divisors stay exact.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             sign_a_in, sign_b_in;

    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr_q};

`ifdef DIV_SIGNED_EN
    assign sign_a_in = sign_op & a[WIDTH-1];
    assign sign_b_in = sign_op & b[WIDTH-1];
`else
    logic unused_sign_op;
    assign unused_sign_op = sign_op;
    assign sign_a_in      = 1'b0;
    assign sign_b_in      = 1'b0;
`endif

    always_comb begin
        state_nx     = state_q;
        rem_nx       = rem_q;
        dvd_nx       = dvd_q;
        dsr_nx       = dsr_q;
        a_raw_nx     = a_raw_q;
        cnt_nx       = cnt_q;
        sign_a_nx    = sign_a_q;
        sign_b_nx    = sign_b_q;
        quotient_nx  = quotient;
        remainder_nx = remainder;
        busy_nx      = busy;
        done_nx      = 1'b0;
        dbz_nx       = div_by_zero;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_a_nx = sign_a_in;
                    sign_b_nx = sign_b_in;
                    dvd_nx    = sign_a_in ? WIDTH'(~a + 1'b1) : a;
                    dsr_nx    = sign_b_in ? WIDTH'(~b + 1'b1) : b;
                    a_raw_nx  = a;
                    rem_nx    = '0;
                    cnt_nx    = '0;
                    busy_nx   = 1'b1;
                    state_nx  = (b == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_nx = trial[WIDTH-1:0];
                    dvd_nx = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_nx = shifted[WIDTH-1:0];
                    dvd_nx = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_nx = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                if (dsr_q == '0) begin
                    quotient_nx  = '1;
                    remainder_nx = a_raw_q;
                    dbz_nx       = 1'b1;
                end else begin
`ifdef DIV_SIGNED_EN
                    quotient_nx  = (sign_a_q ^ sign_b_q) ? WIDTH'(~dvd_q + 1'b1) : dvd_q;
                    remainder_nx = sign_a_q ? WIDTH'(~rem_q + 1'b1) : rem_q;
`else
                    quotient_nx  = dvd_q;
                    remainder_nx = rem_q;
`endif
                    dbz_nx       = 1'b0;
                end
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            a_raw_q     <= '0;
            cnt_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_nx;
            rem_q       <= rem_nx;
            dvd_q       <= dvd_nx;
            dsr_q       <= dsr_nx;
            a_raw_q     <= a_raw_nx;
            cnt_q       <= cnt_nx;
            sign_a_q    <= sign_a_nx;
            sign_b_q    <= sign_b_nx;
            quotient    <= quotient_nx;
            remainder   <= remainder_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            div_by_zero <= dbz_nx;
        end
    end

endmodule
